// File: rtl/vending_pkg.sv
// Shared types and coin constants for the vending controller.
// Optional cancel support is enabled with VENDING_CANCEL_EN.
package vending_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    CREDIT   = 2'd1,
    DISPENSE = 2'd2,
    CHANGE   = 2'd3
  } state_t;

  localparam logic [2:0] C50  = 3'd1;
  localparam logic [2:0] C100 = 3'd2;
  localparam logic [2:0] C200 = 3'd4;

  typedef struct packed {
    logic t200;
    logic t100;
    logic t50;
  } coin_t;

  function automatic logic [2:0] coin_sum(
    input logic r50,
    input logic r100,
    input logic r200
  );
    return (r50  ? C50  : 3'd0)
         + (r100 ? C100 : 3'd0)
         + (r200 ? C200 : 3'd0);
  endfunction

endpackage

// File: rtl/vending_ctrl_change_sel.sv
// Greedy change-coin picker: largest coin not above credit.
// Outputs the one-hot coin and the credit left after paying it.
module change_sel
  import vending_pkg::*;
#(
  parameter int CRED_W = 5
) (
  input  logic [CRED_W-1:0] credit,
  output coin_t             coin,
  output logic [CRED_W-1:0] nxt
);

  localparam logic [CRED_W-1:0] V50  = CRED_W'(C50);
  localparam logic [CRED_W-1:0] V100 = CRED_W'(C100);
  localparam logic [CRED_W-1:0] V200 = CRED_W'(C200);

  always_comb begin
    coin = '0;
    nxt  = credit;
    unique case (1'b1)
      (credit >= V200): begin
        coin.t200 = 1'b1;
        nxt       = credit - V200;
      end
      (credit >= V100 && credit < V200): begin
        coin.t100 = 1'b1;
        nxt       = credit - V100;
      end
      (credit == V50): begin
        coin.t50 = 1'b1;
        nxt      = credit - V50;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/vending_ctrl.sv
// Vending machine controller: coin credit, purchase, greedy change.
// Define VENDING_CANCEL_EN to add a cancel (refund) input.
module vending_ctrl
  import vending_pkg::*;
#(
  parameter int N_PROD = 2,
  parameter int CRED_W = 5,
  parameter logic [N_PROD*CRED_W-1:0] PRICES = {5'd3, 5'd2}
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      r50,
  input  logic                      r100,
  input  logic                      r200,
  input  logic [$clog2(N_PROD)-1:0] sel,
  input  logic                      buy,
`ifdef VENDING_CANCEL_EN
  input  logic                      cancel,
`endif
  output logic                      dispense,
  output logic [$clog2(N_PROD)-1:0] prod,
  output logic                      t50,
  output logic                      t100,
  output logic                      t200,
  output logic                      short,
  output logic                      rej,
  output logic [CRED_W-1:0]         credit,
  output logic [1:0]                state
);

  localparam int SW = $clog2(N_PROD);

  state_t            st;
  coin_t             coin;
  logic [CRED_W-1:0] chg_nxt;
  logic [CRED_W-1:0] price;
  logic [CRED_W-1:0] base;
  logic [CRED_W-1:0] nxt_credit;
  logic [CRED_W:0]   ext;
  logic [2:0]        sum;
  logic              sel_ok;
  logic              go_cancel;
  logic              go_buy;
  logic              go_short;
  logic              do_chg;
  logic              has_credit;
  logic              ovf;
  logic              add_ok;

  change_sel #(.CRED_W(CRED_W)) u_chg (
    .credit (credit),
    .coin   (coin),
    .nxt    (chg_nxt)
  );

  always_comb begin
    price  = '0;
    sel_ok = 1'b0;
    for (int i = 0; i < N_PROD; i++) begin
      if (sel == SW'(i)) begin
        price  = PRICES[i*CRED_W +: CRED_W];
        sel_ok = 1'b1;
      end
    end
  end

`ifdef VENDING_CANCEL_EN
  assign go_cancel = (st == CREDIT) && cancel;
`else
  assign go_cancel = 1'b0;
`endif

  assign sum        = coin_sum(r50, r100, r200);
  assign has_credit = |credit;
  assign go_buy     = (st == CREDIT) && buy && !go_cancel
                    && sel_ok && (credit >= price);
  assign go_short   = (st == IDLE || st == CREDIT) && buy
                    && !go_cancel && !go_buy;
  assign do_chg     = go_cancel
                    || ((st == DISPENSE || st == CHANGE) && has_credit);

  // Deductions first, then coins; an overflowing coin sum is dropped whole.
  always_comb begin
    base = credit;
    unique case (1'b1)
      go_buy:  base = credit - price;
      do_chg:  base = chg_nxt;
      default: ;
    endcase
  end

  assign ext        = {1'b0, base} + (CRED_W+1)'(sum);
  assign ovf        = ext[CRED_W];
  assign nxt_credit = ovf ? base : ext[CRED_W-1:0];
  assign add_ok     = !ovf && (|sum);
  assign state      = st;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st       <= IDLE;
      credit   <= '0;
      dispense <= 1'b0;
      prod     <= '0;
      t50      <= 1'b0;
      t100     <= 1'b0;
      t200     <= 1'b0;
      short    <= 1'b0;
      rej      <= 1'b0;
    end else begin
      credit   <= nxt_credit;
      rej      <= ovf;
      short    <= go_short;
      dispense <= go_buy;
      t50      <= do_chg & coin.t50;
      t100     <= do_chg & coin.t100;
      t200     <= do_chg & coin.t200;
      if (go_buy) prod <= sel;
      unique case (st)
        IDLE: begin
          if (add_ok) st <= CREDIT;
        end
        CREDIT: begin
          if (go_cancel)   st <= CHANGE;
          else if (go_buy) st <= DISPENSE;
        end
        DISPENSE, CHANGE: begin
          if (has_credit)  st <= CHANGE;
          else if (add_ok) st <= CREDIT;
          else             st <= IDLE;
        end
        default: st <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/vending_ctrl.md
VENDING_CTRL -- requirements
Module: vending_ctrl

Interface
REQ-001 Parameter N_PROD, default 2: number of selectable products (>=2).
REQ-002 Parameter CRED_W, default 5: credit register width, in 50-cent units.
REQ-003 Parameter PRICES, default {5'd3,5'd2}: packed N_PROD x CRED_W prices in 50-cent units; product 0 = 2 (1.00), product 1 = 3 (1.50).
REQ-004 clk  in  1  single clock; all state updates on its rising edge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 r50 / r100 / r200  in  1 each  one-cycle coin-insert pulses, worth 1 / 2 / 4 units.
REQ-007 sel  in  $clog2(N_PROD)  product select, sampled with buy.
REQ-008 buy  in  1  one-cycle purchase request.
REQ-009 dispense  out  1  one-cycle product-release pulse.
REQ-010 prod  out  $clog2(N_PROD)  product id, valid while dispense=1.
REQ-011 t50 / t100 / t200  out  1 each  one-cycle change-coin pulses; at most one high per cycle.
REQ-012 short  out  1  one-cycle pulse: buy refused.
REQ-013 rej  out  1  one-cycle pulse: a coin was refused on overflow.
REQ-014 credit  out  CRED_W  current credit.
REQ-015 state  out  2  current FSM state encoding.

Function
REQ-016 The FSM SHALL have states IDLE (credit=0), CREDIT (credit>0), DISPENSE, CHANGE.
REQ-017 All outputs SHALL be registered; every response appears on the edge after the stimulus.
REQ-018 Coin pulses arriving in the same cycle SHALL be summed, and the sum added to credit in every state.
REQ-019 If credit+sum exceeds 2^CRED_W-1, the whole sum SHALL be discarded, credit held, and rej pulsed.
REQ-020 IDLE -> CREDIT SHALL occur when an accepted coin sum is nonzero.
REQ-021 In CREDIT, a buy with the registered (pre-coin) credit >= PRICES[sel] SHALL enter DISPENSE; credit becomes credit-price+sum, and prod latches sel.
REQ-022 In IDLE or CREDIT, a buy with credit < price, or with sel >= N_PROD, SHALL pulse short and leave state and credit unchanged (coins still added).
REQ-023 DISPENSE SHALL last exactly one cycle with dispense=1, then go to CHANGE if credit>0, otherwise IDLE.
REQ-024 Each CHANGE cycle SHALL pulse exactly one coin, greedy: t200 if credit>=4, else t100 if >=2, else t50; that coin's value is subtracted.
REQ-025 CHANGE -> IDLE SHALL occur on the cycle credit reaches 0.
REQ-026 buy SHALL be ignored in DISPENSE and CHANGE (no short pulse).

Reset
REQ-027 While rst_n=0, state=IDLE, credit=0, and all pulse outputs and prod SHALL be 0, immediately and regardless of clk.
REQ-028 Reset mid-DISPENSE or mid-CHANGE SHALL discard the remaining credit without emitting change.

Configuration
REQ-029 Macro VENDING_CANCEL_EN SHALL add an input port cancel (1 bit, one-cycle pulse).
REQ-030 With VENDING_CANCEL_EN defined, cancel in CREDIT SHALL enter CHANGE and refund all credit.
REQ-031 With VENDING_CANCEL_EN defined, cancel SHALL take priority over a simultaneous buy (no dispense, no short).
REQ-032 With VENDING_CANCEL_EN defined, cancel in other states SHALL be ignored.
REQ-033 Without VENDING_CANCEL_EN, the cancel port SHALL be absent and credit is returned only after a purchase.

Structure
REQ-034 Package vending_pkg SHALL hold the state enum and the coin-value constants C50=1, C100=2, C200=4.
REQ-035 Sub-module change_sel SHALL implement the greedy coin choice and decrement (credit in -> coin one-hot, next credit).

Verification (N_PROD=2, CRED_W=5, default PRICES)
REQ-036 Insert r50 then r100 (credit 3), buy sel=0 -> dispense with prod=0, then t50 for one cycle, then IDLE with credit=0.
REQ-037 Insert r200 twice (credit 8), buy sel=1 -> dispense with prod=1, then t200, then t50 on consecutive cycles, then IDLE.
REQ-038 Insert r50 (credit 1), buy sel=0 -> short pulse; credit stays 1; state stays CREDIT.
REQ-039 Reach credit 30 (7x r200 + 1x r100), then r200 -> rej pulse; credit stays 30.
REQ-040 With VENDING_CANCEL_EN: credit 3, cancel and buy together -> t100 then t50, no dispense, then IDLE.
REQ-041 Credit 8, buy sel=1, drop rst_n during the first CHANGE cycle -> credit=0, state IDLE, no further t* pulses.
